// File: rtl/intr_ctrl_if.sv
// Signal bundle between the interrupt sequencer and the core/CCR side.
// No valid/ready pairs here: every input strobe is single-cycle and qualified only by stall.
interface intr_ctrl_if;
  logic       irq_in;
  logic       instr_boundary;
  logic       stall;
  logic       rti_exec;
  logic       intr;
  logic       rti;
  logic       irq_ack;
  logic       vec_fetch;
  logic       in_isr;
  logic       irq_pend;
  logic       err_rti;
  logic [2:0] dbg_state;

  modport master (
    output irq_in, instr_boundary, stall, rti_exec,
    input  intr, rti, irq_ack, vec_fetch, in_isr, irq_pend, err_rti, dbg_state
  );

  modport slave (
    input  irq_in, instr_boundary, stall, rti_exec,
    output intr, rti, irq_ack, vec_fetch, in_isr, irq_pend, err_rti, dbg_state
  );
endinterface

// File: rtl/intr_ctrl.sv
// Interrupt sequencer driving the CCR save (intr) and restore (rti) strobes.
// Define INTR_SYNC_EN to put a two-flop synchronizer in front of the irq edge detector.
module intr_ctrl #(
  parameter int unsigned VEC_CYCLES = 2
) (
  input  logic      clk,
  input  logic      rst,
  intr_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ENTER  = 3'd1,
    VECTOR = 3'd2,
    ISR    = 3'd3,
    LEAVE  = 3'd4
  } state_e;

  localparam logic [3:0] VEC_LAST = 4'(VEC_CYCLES - 1);

  state_e     state_q;
  logic [3:0] cnt_q;
  logic       prev_q;
  logic       pend_q;
  logic       err_q;
  logic       req;
  logic       edge_det;
  logic       rti_ok;

`ifdef INTR_SYNC_EN
  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign req = sync2_q;
`else
  assign req = bus.irq_in;
`endif

  assign edge_det = req & ~prev_q;
  assign rti_ok   = bus.rti_exec & ~bus.stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      prev_q <= req;
      // A new edge arriving in ENTER keeps the request pending for re-entry.
      pend_q <= edge_det | (pend_q & (state_q != ENTER));
      if (state_q == IDLE && rti_ok) err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (pend_q & bus.instr_boundary & ~bus.stall) state_q <= ENTER;
        end
        ENTER: begin
          cnt_q   <= '0;
          state_q <= VECTOR;
        end
        VECTOR: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == VEC_LAST) state_q <= ISR;
        end
        ISR: begin
          if (rti_ok) state_q <= LEAVE;
        end
        LEAVE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.intr      = (state_q == ENTER);
  assign bus.irq_ack   = (state_q == ENTER);
  assign bus.vec_fetch = (state_q == VECTOR);
  assign bus.in_isr    = (state_q == ISR);
  assign bus.rti       = (state_q == LEAVE);
  assign bus.irq_pend  = pend_q;
  assign bus.err_rti   = err_q;
  assign bus.dbg_state = state_q;

endmodule

// File: doc/intr_ctrl.md
# intr_ctrl

Interrupt sequencer that sits directly upstream of the condition-code register and drives its `intr` and `rti` strobes. It captures an external interrupt request, waits for a safe instruction boundary, and issues a one-cycle `intr` pulse so the CCR saves flags. It then holds the core in vector fetch for a fixed number of cycles and tracks the service routine. When the return-from-interrupt instruction executes, it issues a one-cycle `rti` pulse so the CCR restores flags.

## Interface
- `VEC_CYCLES`, default 2: cycles spent in vector fetch after entry; legal range 1..15.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low; one clock domain only.
- `irq_in`  in  1  external interrupt request; level held by source, edge-triggered here.
- `instr_boundary`  in  1  high when the pipeline is between instructions and an interrupt may be taken.
- `stall`  in  1  pipeline stall; blocks entry and RTI acceptance.
- `rti_exec`  in  1  single-cycle strobe from decode: an RTI instruction is executing.
- `intr`  out  1  single-cycle strobe to CCR: save flags.
- `rti`  out  1  single-cycle strobe to CCR: restore flags.
- `irq_ack`  out  1  single-cycle acknowledge to source, coincident with `intr`.
- `vec_fetch`  out  1  high for exactly `VEC_CYCLES` cycles; fetch unit loads the vector.
- `in_isr`  out  1  high while the service routine runs.
- `irq_pend`  out  1  request captured and not yet taken.
- `err_rti`  out  1  sticky: an RTI was accepted while not in service.

## Operation
- Edge detect: a `prev` flop holds the last sampled request. The request is `irq_in` with `INTR_SYNC_EN` undefined, or the synchronizer output with it defined. `edge_det` = request & ~prev.
- Pending latch `pend` is set by `edge_det` and cleared in ENTER. Set wins over clear in the same cycle. A further edge while `pend`=1 merges; no count is kept.
- FSM states: IDLE, ENTER, VECTOR, ISR, LEAVE.
- IDLE: `pend` & `instr_boundary` & ~`stall` -> ENTER. Otherwise stay in IDLE.
- ENTER (1 cycle): `intr`=1, `irq_ack`=1, `pend` cleared, vector counter loaded with 0. Next state is VECTOR.
- VECTOR: `vec_fetch`=1. The counter increments each cycle. Leave for ISR after the cycle with counter = `VEC_CYCLES`-1. `stall` does not extend VECTOR.
- ISR: `in_isr`=1. New edges set `pend`; there is no nesting. `rti_exec` & ~`stall` -> LEAVE.
- LEAVE (1 cycle): `rti`=1. Next state is IDLE. A still-pending request re-enters via the IDLE rule.
- `rti_exec` & ~`stall` in IDLE sets `err_rti`. The RTI is then discarded and no `rti` pulse is issued.
- `rti_exec` in ENTER, VECTOR or LEAVE is ignored and does not set `err_rti`.
- `intr` and `rti` are never high in the same cycle.

## Timing
- Reset (`rst`=0, asynchronous): state goes to IDLE. `pend`, `prev`, the synchronizer flops, the counter, `err_rti` and every output go to 0.
- Reset mid-sequence aborts the sequence with no `rti` pulse. The first edge after release sees `prev`=0, so a high `irq_in` at release counts as a new edge.
- All outputs are decoded from registered state. None depend combinationally on inputs.
- Request latency, `INTR_SYNC_EN` undefined: `irq_in` first sampled high at edge t0 gives `irq_pend`=1 after t0.
- Request latency, `INTR_SYNC_EN` defined: `irq_pend`=1 after t0+2.
- Entry: `pend`=1 with a boundary and no stall sampled at edge t gives `intr`/`irq_ack` high in cycle t+1.
- `vec_fetch` is high in cycles t+2 .. t+1+`VEC_CYCLES`. `in_isr` is high from t+2+`VEC_CYCLES`.
- Exit: `rti_exec` & ~`stall` sampled at edge r gives `rti` high in cycle r+1 and IDLE from r+2.
- Minimum gap between `rti` and the next `intr` is 1 cycle (IDLE).

## Configuration
- `INTR_SYNC_EN` defined: `irq_in` passes through a two-flop synchronizer before edge detect. This adds 2 cycles of request latency. Use it when the source is asynchronous.
- `INTR_SYNC_EN` undefined: `irq_in` goes straight to edge detect. It must be synchronous to `clk`.

## Test plan
- Reset: hold `rst`=0 with `irq_in`=1 -> all outputs 0.
- Reset release with `irq_in` held high -> `irq_pend`=1 after 1 edge (sync off) or 3 edges (sync on).
- Basic entry with `VEC_CYCLES`=2 and `instr_boundary`=1: pulse `irq_in` -> one `intr`/`irq_ack` cycle, then `vec_fetch` for 2 cycles, then `in_isr`=1.
- Exit: strobe `rti_exec` in ISR -> one-cycle `rti` next cycle, then IDLE with `in_isr`=0.
- Boundary/stall gating: `pend`=1 with `instr_boundary`=0 for 5 cycles, then `instr_boundary`=1 and `stall`=1 for 2 cycles -> no `intr` until the first cycle after boundary=1 and stall=0 are sampled together.
- Simultaneous events: `irq_in` edge detected in the ENTER cycle -> `irq_pend` stays 1 and re-entry follows the LEAVE/IDLE cycle.
- Spurious RTI: `rti_exec` in IDLE -> `err_rti`=1 sticky and no `rti` pulse.
- RTI during VECTOR: `rti_exec` strobed -> ignored and `err_rti` stays 0.
